// File: rtl/sprite_pkg.sv
// Shared types for the sprite layer: scale encoding, pipeline latency and scale clamping.
package sprite_pkg;

   typedef enum logic [1:0] {
      SCALE_1X = 2'd0,
      SCALE_2X = 2'd1,
      SCALE_4X = 2'd2
   } scale_e;

   localparam int SPRITE_LATENCY = 3;

   // Code 3 has no 8x mode behind it, so it folds onto 4x.
   function automatic scale_e clamp_scale(input logic [1:0] scale_log2);
      return scale_log2[1] ? SCALE_4X : scale_e'(scale_log2);
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational S0 geometry: box hit test, texel column/row with optional mirror, ROM address.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int  COORD_W = 10,
   parameter int  SPR_W   = 32,
   parameter int  SPR_H   = 32,
   localparam int COL_W   = $clog2(SPR_W),
   localparam int ROW_W   = $clog2(SPR_H)
) (
   input  logic [COORD_W-1:0]     draw_x,
   input  logic [COORD_W-1:0]     draw_y,
   input  logic [COORD_W-1:0]     sh_x,
   input  logic [COORD_W-1:0]     sh_y,
   input  scale_e                 sh_s,
   input  logic                   sh_f,
   output logic                   hit,
   output logic [COL_W+ROW_W-1:0] addr
);

   logic [COORD_W:0] dx, dy;
   logic [COORD_W:0] dx_sh, dy_sh;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             in_x, in_y;

   // NOTE: every variable is assigned unconditionally before any if, so no latch is inferred.
   always_comb begin
      dx    = {1'b0, draw_x} - {1'b0, sh_x};
      dy    = {1'b0, draw_y} - {1'b0, sh_y};
      dx_sh = dx >> sh_s;
      dy_sh = dy >> sh_s;
      // dx < SPR_W<<s is the same test as (dx>>s) < SPR_W, and the shifted form cannot overflow.
      in_x  = (draw_x >= sh_x) && (dx_sh[COORD_W:COL_W] == '0);
      in_y  = (draw_y >= sh_y) && (dy_sh[COORD_W:ROW_W] == '0);
      hit   = in_x && in_y;
      col   = dx_sh[COL_W-1:0];
      row   = dy_sh[ROW_W-1:0];
      if (sh_f) begin
         col = ~col;
      end
      addr  = hit ? {row, col} : '0;
   end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Three-stage sprite layer: S0 address, S1 ROM read, S2 palette/transparency to registered RGB.
// Optional mirror support is compiled in with `define SPRITE_FLIP_EN.
module sprite_layer_renderer
   import sprite_pkg::*;
#(
   parameter int               COORD_W   = 10,
   parameter int               SPR_W     = 32,
   parameter int               SPR_H     = 32,
   parameter int               IDX_W     = 4,
   parameter logic [IDX_W-1:0] TRANS_IDX = '0,
   localparam int              ADDR_W    = $clog2(SPR_W*SPR_H)
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic               blank,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   input  logic [1:0]         scale_log2,
   input  logic               flip_h,
   output logic [ADDR_W-1:0]  rom_address,
   input  logic [IDX_W-1:0]   rom_q,
   output logic [IDX_W-1:0]   pal_index,
   input  logic [3:0]         pal_red,
   input  logic [3:0]         pal_green,
   input  logic [3:0]         pal_blue,
   output logic [3:0]         red,
   output logic [3:0]         green,
   output logic [3:0]         blue,
   output logic               sprite_on
);

   logic [COORD_W-1:0]        sh_x_q, sh_x_d;
   logic [COORD_W-1:0]        sh_y_q, sh_y_d;
   scale_e                    sh_s_q, sh_s_d;
   logic                      sh_f;
   logic                      s0_hit;
   logic [ADDR_W-1:0]         s0_addr;
   logic [ADDR_W-1:0]         rom_addr_q;
   logic [SPRITE_LATENCY-2:0] vld_q;
   logic                      opaque;
   logic [11:0]               rgb_q, rgb_d;
   logic                      sprite_on_q;

`ifdef SPRITE_FLIP_EN
   logic sh_f_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_f_q <= 1'b0;
      end else if (frame_start) begin
         sh_f_q <= flip_h;
      end
   end

   assign sh_f = sh_f_q;
`else
   logic unused_flip;

   assign unused_flip = flip_h;
   assign sh_f        = 1'b0;
`endif

   sprite_addr_gen #(
      .COORD_W (COORD_W),
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H)
   ) u_addr_gen (
      .draw_x (DrawX),
      .draw_y (DrawY),
      .sh_x   (sh_x_q),
      .sh_y   (sh_y_q),
      .sh_s   (sh_s_q),
      .sh_f   (sh_f),
      .hit    (s0_hit),
      .addr   (s0_addr)
   );

   always_comb begin
      sh_x_d = sh_x_q;
      sh_y_d = sh_y_q;
      sh_s_d = sh_s_q;
      if (frame_start) begin
         sh_x_d = pos_x;
         sh_y_d = pos_y;
         sh_s_d = clamp_scale(scale_log2);
      end
      opaque = vld_q[SPRITE_LATENCY-2] && (rom_q != TRANS_IDX);
      rgb_d  = opaque ? {pal_red, pal_green, pal_blue} : 12'h000;
   end

   // Shadows update on the same edge that consumes them, so a pixel alongside frame_start sees the old frame.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_s_q      <= SCALE_1X;
         rom_addr_q  <= '0;
         vld_q       <= '0;
         rgb_q       <= '0;
         sprite_on_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let each stage capture the previous stage's pre-edge value.
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_s_q      <= sh_s_d;
         rom_addr_q  <= s0_addr;
         vld_q       <= {vld_q[SPRITE_LATENCY-3:0], s0_hit & blank};
         rgb_q       <= rgb_d;
         sprite_on_q <= opaque;
      end
   end

   assign rom_address = rom_addr_q;
   assign pal_index   = rom_q;
   assign red         = rgb_q[11:8];
   assign green       = rgb_q[7:4];
   assign blue        = rgb_q[3:0];
   assign sprite_on   = sprite_on_q;

endmodule
